branch_resolve: RTL
===================

# branch_resolve

Branch-resolution stage directly downstream of the ALU comparator. It captures the comparator's 4-bit flag vector into a condition-flag register and evaluates a branch condition code against those flags on request. It computes the next PC (taken target or fall-through) and returns the result over a valid/ready handshake. On a taken branch it drives a multi-cycle pipeline flush.

## Interface
- `FLUSH_CYCLES`, default 2: number of cycles `flush` stays high after a taken branch is handed off; legal range 1–15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flag_we` in 1: writes `flags_in` into the flag register.
- `flags_in` in 4: comparator flags, `{lt, eq, slt, ovf}` (bit 3 down to bit 0).
- `br_valid` in 1: branch request valid.
- `br_ready` out 1: block can accept a request.
- `br_cond` in 4: condition code.
- `br_pc` in 32: PC of the branch.
- `br_offset` in 32: signed word offset.
- `res_valid` out 1: result valid.
- `res_ready` in 1: consumer accepts the result.
- `res_taken` out 1: branch taken.
- `res_target` out 32: next PC.
- `res_illegal` out 1: reserved condition code was received.
- `flush` out 1: squash younger pipeline stages.
- `flags_q` out 4: current flag register contents.
- `stat_total` out 16: branch count, present under `BRANCH_STATS_EN`.
- `stat_taken` out 16: taken-branch count, present under `BRANCH_STATS_EN`.

## Operation
- **Flag register**
  - Loads `flags_in` on any edge with `flag_we=1`, in every FSM state.
  - Reset value is 0.
- **Effective flags for evaluation**
  - If `flag_we` is high on the acceptance edge, the request evaluates `flags_in` (forwarding).
  - Otherwise it evaluates `flags_q`.
- **Condition codes**
  - 0 EQ: `eq`
  - 1 NE: `!eq`
  - 2 LT: `lt`
  - 3 GE: `!lt`
  - 4 LE: `lt|eq`
  - 5 GT: `!lt&!eq`
  - 6 VS: `ovf`
  - 7 VC: `!ovf`
  - 8 SLT: `slt`
  - 9 SGE: `!slt`
  - 10 AL: taken
  - 11 NV: not taken
  - 12–15: not taken, with `res_illegal=1`.
- **Target arithmetic**
  - Taken: `br_pc + (br_offset << 2)`.
  - Not taken: `br_pc + 4`.
  - 32-bit modulo, carry discarded; wrap past 0xFFFFFFFF is legal.
- **FSM states**
  - IDLE: `br_ready=1`. On `br_valid`, register the result and go to RESOLVE.
  - RESOLVE: `res_valid=1`; `res_taken`, `res_target` and `res_illegal` are held stable.
    - On `res_ready`: go to FLUSH if taken, else to IDLE.
  - FLUSH: `flush=1`, `br_ready=0`. A down-counter loaded with `FLUSH_CYCLES` decrements each cycle; returns to IDLE after `FLUSH_CYCLES` cycles.
- Only one branch is in flight at a time.
- `br_ready` is low in RESOLVE and FLUSH.

## Timing
- **Reset values**
  - FSM is IDLE.
  - `br_ready=1`.
  - `res_valid`, `res_taken`, `res_illegal` and `flush` are 0.
  - `res_target=0`, `flags_q=0`.
  - Stats are 0.
- **Latency**
  - Request accepted on edge N; `res_valid=1` from cycle N+1.
  - Result handshake on edge M:
    - Taken: `flush=1` for cycles M+1 to M+`FLUSH_CYCLES`, and `br_ready=1` again at M+`FLUSH_CYCLES`+1.
    - Not taken: `br_ready=1` at M+1.
- **Back-pressure**
  - `res_ready` low holds RESOLVE indefinitely with outputs frozen.
  - `flag_we` during RESOLVE updates `flags_q` only and does not alter the pending result.
- **Simultaneous events**
  - `flag_we` together with branch acceptance: the new flags are used and also stored.
- **Reset mid-operation**
  - Asserting `rst` in any state forces the reset values immediately (asynchronously).
  - Any in-flight branch is discarded, and `flush` drops without completing its count.
- Outputs are registered; there is no combinational path from `br_*` to `res_*`.

## Configuration
- Macro `BRANCH_STATS_EN`.
- **Defined**
  - `stat_total` increments on each result handshake.
  - `stat_taken` increments on each taken result handshake.
  - Both are 16-bit and saturate at 0xFFFF.
- **Undefined**
  - Counters are not built; `stat_total` and `stat_taken` are tied to 0.

## Test plan
- **Forwarded EQ, taken:** `flag_we=1` with `flags_in=4'b0100`, same edge as a request with cond 0, `br_pc=0x100`, `br_offset=3`.
  - Expect `res_taken=1` and `res_target=0x10C` the next cycle.
  - After `res_ready`, `flush` is high for exactly 2 cycles, and `br_ready` stays low until `flush` drops.
- **GE, not taken:** `flags_q=4'b1000`, cond 3, `br_pc=0x200`.
  - Expect `res_taken=0`, `res_target=0x204`, `flush` never asserted, and `br_ready` high the cycle after the handshake.
- **Back-pressure with flag write:** hold `res_ready=0` for 5 cycles while pulsing `flag_we` with `4'b0100`.
  - The result stays frozen; `flags_q` becomes `4'b0100`.
- **Wrap and illegal code:**
  - cond 10, `br_pc=0xFFFFFFF8`, `br_offset=4` → `res_target=0x00000008`.
  - cond 13 → `res_taken=0`, `res_illegal=1`.
- **Reset mid-flush:** assert `rst` during the first FLUSH cycle.
  - `flush`, `res_valid` and `flags_q` go to 0 immediately; `br_ready=1`.
- **Stats (macro defined):** 3 taken and 2 not-taken handshakes → `stat_total=5`, `stat_taken=3`.
  - Preloaded at 0xFFFF, they stay at 0xFFFF.

Source files
------------

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - branch condition evaluation, next-PC resolution and flush sequencing
//
// Purpose:
//   Holds the ALU comparator flags {lt, eq, slt, ovf}. It evaluates a
//   condition code against those flags, and forwards flags_in when flag_we
//   coincides with acceptance. It computes the next PC and returns the result
//   over a valid/ready handshake. A taken branch raises flush for FLUSH_CYCLES
//   cycles after its result is consumed.
//
// Optional feature macro: BRANCH_STATS_EN (saturating branch / taken counters).
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   flag_we, flags_in[3:0]    flag register write
//   br_valid/br_ready         request handshake
//   br_cond, br_pc, br_offset request payload
//   res_valid/res_ready       result handshake
//   res_taken, res_target     branch outcome and next PC
//   res_illegal               reserved condition code seen
//   flush                     squash younger stages
//   flags_q                   current flag register
//   stat_total, stat_taken    counters (0 unless BRANCH_STATS_EN)

module branch_resolve #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flag_we,
  input  logic [3:0]  flags_in,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [3:0]  br_cond,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_offset,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_taken,
  output logic [31:0] res_target,
  output logic        res_illegal,
  output logic        flush,
  output logic [3:0]  flags_q,
  output logic [15:0] stat_total,
  output logic [15:0] stat_taken
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESOLVE = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t      state;
  logic [3:0]  flush_cnt;
  logic [3:0]  eff_flags;
  logic        cond_taken;
  logic        cond_illegal;
  logic [31:0] next_pc;
  logic        res_hs;

  // Flag register: written in every state, independent of the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'd0;
    end else if (flag_we) begin
      flags_q <= flags_in;
    end
  end

  // Same-edge flag write is forwarded into the evaluation.
  always_comb begin
    eff_flags    = flag_we ? flags_in : flags_q;
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    case (br_cond)
      4'd0:    cond_taken = eff_flags[2];
      4'd1:    cond_taken = !eff_flags[2];
      4'd2:    cond_taken = eff_flags[3];
      4'd3:    cond_taken = !eff_flags[3];
      4'd4:    cond_taken = eff_flags[3] | eff_flags[2];
      4'd5:    cond_taken = !eff_flags[3] & !eff_flags[2];
      4'd6:    cond_taken = eff_flags[0];
      4'd7:    cond_taken = !eff_flags[0];
      4'd8:    cond_taken = eff_flags[1];
      4'd9:    cond_taken = !eff_flags[1];
      4'd10:   cond_taken = 1'b1;
      4'd11:   cond_taken = 1'b0;
      default: cond_illegal = 1'b1;
    endcase
    // Modulo-2^32 sum; wrap past the top of the address space is intended.
    next_pc = cond_taken ? (br_pc + {br_offset[29:0], 2'b00}) : (br_pc + 32'd4);
  end

  assign res_hs = res_valid && res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      br_ready    <= 1'b1;
      res_valid   <= 1'b0;
      res_taken   <= 1'b0;
      res_target  <= 32'd0;
      res_illegal <= 1'b0;
      flush       <= 1'b0;
      flush_cnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (br_valid) begin
            res_taken   <= cond_taken;
            res_target  <= next_pc;
            res_illegal <= cond_illegal;
            res_valid   <= 1'b1;
            br_ready    <= 1'b0;
            state       <= S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (res_taken) begin
              flush     <= 1'b1;
              flush_cnt <= FLUSH_LOAD;
              state     <= S_FLUSH;
            end else begin
              br_ready <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          // Exit on the edge that ends the last flush cycle so br_ready
          // rises exactly as flush falls.
          if (flush_cnt <= 4'd1) begin
            flush     <= 1'b0;
            flush_cnt <= 4'd0;
            br_ready  <= 1'b1;
            state     <= S_IDLE;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state    <= S_IDLE;
          br_ready <= 1'b1;
          flush    <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_total <= 16'd0;
      stat_taken <= 16'd0;
    end else if (res_hs) begin
      if (stat_total != 16'hFFFF) stat_total <= stat_total + 16'd1;
      if (res_taken && (stat_taken != 16'hFFFF)) stat_taken <= stat_taken + 16'd1;
    end
  end
`else
  logic unused_hs;
  assign unused_hs  = res_hs;
  assign stat_total = 16'd0;
  assign stat_taken = 16'd0;
`endif

endmodule
